fp32_mant_normalizer: RTL and testbench

//  Post-add/sub normalizer for the FP32 datapath: takes an unnormalized 32-bit mantissa and biased

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/lzc_32bit.sv | 54 +++++
 rtl/fp32_mant_normalizer.sv | 102 ++++++++++
 tb/tb_fp32_mant_normalizer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 datapath widths and the normalizer request/response bundles.
// Imported by the leading-zero counter and the normalizer top.
package fpu_pkg;

  localparam int MANT_W = 32;
  localparam int EXP_W  = 8;
  localparam int LZC_W  = $clog2(MANT_W);

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
  } norm_req_t;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic [LZC_W-1:0]  shift;
    logic              denorm;
    logic              zero;
  } norm_rsp_t;

endpackage

// File: rtl/lzc_32bit.sv
// Combinational 32-bit leading-zero counter built as a tree of 2-bit cells.
// Ports: data (in, 32), count (out, 5, leading zeros), all_zero (out, data==0).
module lzc_32bit
  import fpu_pkg::*;
(
  input  logic [MANT_W-1:0] data,
  output logic [LZC_W-1:0]  count,
  output logic              all_zero
);

  // Level 0: one cell per bit pair, pair i covers bits 2i+1:2i.
  logic [15:0] z0;
  logic [15:0] c0;

  // Merged levels; index j+1 is always the more significant half.
  logic [7:0] z1;
  logic [1:0] c1 [8];
  logic [3:0] z2;
  logic [2:0] c2 [4];
  logic [1:0] z3;
  logic [3:0] c3 [2];

  genvar i;

  for (i = 0; i < 16; i++) begin : g_l0
    assign z0[i] = ~|data[2*i+1 -: 2];
    assign c0[i] = ~data[2*i+1];
  end

  // When the upper half is empty the count is its full width plus
  // the lower count, i.e. a 1 prepended to the lower count.
  for (i = 0; i < 8; i++) begin : g_l1
    assign z1[i] = z0[2*i+1] & z0[2*i];
    assign c1[i] = z0[2*i+1] ? {1'b1, c0[2*i]}
                             : {1'b0, c0[2*i+1]};
  end

  for (i = 0; i < 4; i++) begin : g_l2
    assign z2[i] = z1[2*i+1] & z1[2*i];
    assign c2[i] = z1[2*i+1] ? {1'b1, c1[2*i]}
                             : {1'b0, c1[2*i+1]};
  end

  for (i = 0; i < 2; i++) begin : g_l3
    assign z3[i] = z2[2*i+1] & z2[2*i];
    assign c3[i] = z2[2*i+1] ? {1'b1, c2[2*i]}
                             : {1'b0, c2[2*i+1]};
  end

  assign all_zero = z3[1] & z3[0];
  assign count    = z3[1] ? {1'b1, c3[0]}
                          : {1'b0, c3[1]};

endmodule

// File: rtl/fp32_mant_normalizer.sv
// Two-stage post-add normalizer: LZC, then left shift with exponent floor.
// Ports: i_clk, i_rst, i_valid/o_ready in, o_valid/i_ready out,
//   i_mant/i_exp request, o_mant/o_exp/o_shift/o_denorm/o_zero response.
module fp32_mant_normalizer
  import fpu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [MANT_W-1:0] i_mant,
  input  logic [EXP_W-1:0]  i_exp,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [MANT_W-1:0] o_mant,
  output logic [EXP_W-1:0]  o_exp,
  output logic [LZC_W-1:0]  o_shift,
  output logic              o_denorm,
  output logic              o_zero
);

  logic             s1_valid;
  norm_req_t        s1_req;
  logic [LZC_W-1:0] s1_lzc;
  logic             s1_zero;

  logic             s2_valid;
  logic             s2_can_load;
  norm_rsp_t        s2_rsp;
  norm_rsp_t        s2_next;

  logic [LZC_W-1:0] lzc_cnt;
  logic             lzc_zero;

  lzc_32bit u_lzc (
    .data     (i_mant),
    .count    (lzc_cnt),
    .all_zero (lzc_zero)
  );

  // Ready chain: a stage may load when empty or when its
  // occupant leaves this cycle.
  assign s2_can_load = ~s2_valid | i_ready;
  assign o_ready     = ~s1_valid | s2_can_load;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
      s1_lzc   <= '0;
      s1_zero  <= 1'b0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_req.mant <= i_mant;
        s1_req.exp  <= i_exp;
        s1_lzc      <= lzc_cnt;
        s1_zero     <= lzc_zero;
      end
    end
  end

  // Exponent floor: never shift the exponent below the subnormal
  // boundary. With 1 <= exp <= lzc the shift stops at exp-1, which
  // always fits in five bits, so exp[4:0]-1 is exact.
  always_comb begin
    s2_next        = '0;
    s2_next.zero   = s1_zero;
    if (s1_zero) begin
      s2_next.shift  = '0;
    end else if (s1_req.exp > {3'b000, s1_lzc}) begin
      s2_next.shift  = s1_lzc;
      s2_next.exp    = s1_req.exp - {3'b000, s1_lzc};
    end else if (s1_req.exp != '0) begin
      s2_next.shift  = s1_req.exp[LZC_W-1:0] - 5'd1;
      s2_next.denorm = 1'b1;
    end else begin
      s2_next.denorm = 1'b1;
    end
    s2_next.mant = s1_req.mant << s2_next.shift;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_rsp   <= '0;
    end else if (s2_can_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_rsp <= s2_next;
      end
    end
  end

  assign o_valid  = s2_valid;
  assign o_mant   = s2_rsp.mant;
  assign o_exp    = s2_rsp.exp;
  assign o_shift  = s2_rsp.shift;
  assign o_denorm = s2_rsp.denorm;
  assign o_zero   = s2_rsp.zero;

endmodule

// File: tb/tb_fp32_mant_normalizer.sv
// Directed bench for fp32_mant_normalizer: reset, corner vectors,
// stalled back-to-back stream checked against a reference model.
module tb_fp32_mant_normalizer;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_mant;
  logic [7:0]  i_exp;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_mant;
  logic [7:0]  o_exp;
  logic [4:0]  o_shift;
  logic        o_denorm;
  logic        o_zero;

  int total = 0;
  int bad   = 0;

  fp32_mant_normalizer dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_mant   (i_mant),
    .i_exp    (i_exp),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_mant   (o_mant),
    .o_exp    (o_exp),
    .o_shift  (o_shift),
    .o_denorm (o_denorm),
    .o_zero   (o_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic norm_rsp_t model(input logic [31:0] m,
                                      input logic [7:0] e);
    norm_rsp_t r;
    int lz;
    r  = '0;
    lz = 32;
    for (int b = 31; b >= 0; b--) begin
      if (m[b] && lz == 32) lz = 31 - b;
    end
    if (m == 0) begin
      r.zero = 1'b1;
    end else if (int'(e) > lz) begin
      r.shift = 5'(lz);
      r.exp   = 8'(int'(e) - lz);
    end else if (e >= 1) begin
      r.shift  = 5'(int'(e) - 1);
      r.denorm = 1'b1;
    end else begin
      r.denorm = 1'b1;
    end
    r.mant = m << r.shift;
    return r;
  endfunction

  task automatic run_one(input string tag, input logic [31:0] m,
                         input logic [7:0] e, input logic [31:0] em,
                         input logic [7:0] ee, input logic [4:0] es,
                         input logic edn, input logic ez);
    int n;
    @(negedge clk);
    i_mant  = m;
    i_exp   = e;
    i_valid = 1'b1;
    #1 chk({tag, ".ready"}, o_ready, 1);
    @(negedge clk);
    i_valid = 1'b0;
    #1 chk({tag, ".lat1"}, o_valid, 0);
    n = 0;
    while (!o_valid && n < 8) begin
      @(negedge clk);
      #1 n++;
    end
    chk({tag, ".valid"}, o_valid, 1);
    chk({tag, ".mant"}, o_mant, em);
    chk({tag, ".exp"}, o_exp, ee);
    chk({tag, ".shift"}, o_shift, es);
    chk({tag, ".denorm"}, o_denorm, edn);
    chk({tag, ".zero"}, o_zero, ez);
  endtask

  logic [31:0] vm [8] = '{32'h0000_0001, 32'h1234_5678, 32'h0000_0010,
                          32'h0000_0000, 32'hFFFF_FFFF, 32'h0080_0000,
                          32'h0000_8000, 32'h4000_0000};
  logic [7:0]  ve [8] = '{8'd200, 8'd100, 8'd5, 8'd3,
                          8'd0, 8'd8, 8'd17, 8'd2};
  bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    norm_rsp_t q[$];
    norm_rsp_t er;
    int sent, recv, cyc, inflight;
    logic acc, del;

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_mant  = '0;
    i_exp   = '0;
    i_ready = 1'b1;
    #3;
    chk("rst.valid", o_valid, 0);
    chk("rst.ready", o_ready, 1);
    chk("rst.mant", o_mant, 0);
    chk("rst.flags", {o_exp, o_shift, o_denorm, o_zero}, 0);
    @(negedge clk);
    i_rst = 1'b0;

    run_one("t2", 32'h0000_1000, 8'd140, 32'h8000_0000, 8'd121,
            5'd19, 1'b0, 1'b0);
    run_one("t3", 32'h0000_0100, 8'd10, 32'h0002_0000, 8'd0,
            5'd9, 1'b1, 1'b0);
    run_one("t4", 32'h0000_0000, 8'd77, 32'h0000_0000, 8'd0,
            5'd0, 1'b0, 1'b1);
    run_one("t6a", 32'h8000_0000, 8'd0, 32'h8000_0000, 8'd0,
            5'd0, 1'b1, 1'b0);
    run_one("t6b", 32'h8000_0000, 8'd1, 32'h8000_0000, 8'd1,
            5'd0, 1'b0, 1'b0);
    run_one("t7", 32'h0000_0003, 8'd255, 32'hC000_0000, 8'd225,
            5'd30, 1'b0, 1'b0);

    sent     = 0;
    recv     = 0;
    cyc      = 0;
    inflight = 0;
    while (recv < 8 && cyc < 100) begin
      @(negedge clk);
      i_ready = pat[cyc % 4];
      i_valid = (sent < 8);
      if (sent < 8) begin
        i_mant = vm[sent];
        i_exp  = ve[sent];
      end
      #1;
      del = o_valid & i_ready;
      chk("t5.ready", o_ready, (inflight == 2 && !i_ready) ? 0 : 1);
      if (del) begin
        chk("t5.qnonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          er = q.pop_front();
          chk("t5.mant", o_mant, er.mant);
          chk("t5.exp", o_exp, er.exp);
          chk("t5.shift", o_shift, er.shift);
          chk("t5.flags", {o_denorm, o_zero}, {er.denorm, er.zero});
        end
        recv++;
      end
      acc = i_valid & o_ready;
      if (acc) begin
        q.push_back(model(vm[sent], ve[sent]));
        sent++;
      end
      inflight = inflight + int'(acc) - int'(del);
      cyc++;
    end
    chk("t5.count", recv, 8);
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;

    @(negedge clk);
    i_ready = 1'b0;
    i_mant  = 32'h0000_00F0;
    i_exp   = 8'd50;
    i_valid = 1'b1;
    @(negedge clk);
    i_mant = 32'h0001_0000;
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("t1.full_valid", o_valid, 1);
    chk("t1.full_ready", o_ready, 0);
    #1 i_rst = 1'b1;
    #1;
    chk("t1.valid", o_valid, 0);
    chk("t1.ready", o_ready, 1);
    chk("t1.mant", o_mant, 0);
    chk("t1.flags", {o_exp, o_shift, o_denorm, o_zero}, 0);
    @(negedge clk);
    i_rst   = 1'b0;
    i_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 chk("t1.no_out", o_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
